csa_seq_accum: RTL and testbench

- Parametrised, sequential carry-save accumulator for the multiplier datapath; successor to the fixed 33-bit 3:2 compressor row.
- Accepts N_ROWS pre-aligned partial-product rows, one per handshake, and folds each row into registered sum/carry vectors with one 3:2 compression per cycle.
- Presents the redundant (sum, carry) pair downstream via valid/ready; the final carry-propagate add is an optional build feature.

---
 rtl/csa_seq_accum.sv | 139 +++++++++++++
 tb/tb_csa_seq_accum.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/csa_seq_accum.sv
// Sequential carry-save accumulator: folds N_ROWS partial-product rows into a
// redundant (sum, carry) pair, one 3:2 compression per accepted row.
// Optional build feature CSA_SEQ_CPA_EN adds a FINAL state and a registered
// carry-propagate result on result_o.
module csa_seq_accum #(
  parameter int W      = 33,
  parameter int N_ROWS = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_row,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o,
`ifdef CSA_SEQ_CPA_EN
  output logic [W-1:0] result_o,
`endif
  output logic         busy
);

  localparam int CNT_W = $clog2(N_ROWS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ROWS - 1);

`ifdef CSA_SEQ_CPA_EN
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_FINAL, S_DONE} state_e;
  localparam state_e S_AFTER_LAST = S_FINAL;
`else
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_e;
  localparam state_e S_AFTER_LAST = S_DONE;
`endif

  state_e           state_q, state_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [W-1:0]     carry_q, carry_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
`ifdef CSA_SEQ_CPA_EN
  logic [W-1:0]     result_q, result_d;
`endif

  logic         accept;
  logic [W-1:0] csa_sum;
  logic [W-2:0] csa_maj;

  // Majority is only kept below the MSB; the top carry falls off (mod 2^W).
  assign csa_sum = sum_q ^ carry_q ^ in_row;
  assign csa_maj = (sum_q[W-2:0] & carry_q[W-2:0])
                 | (sum_q[W-2:0] & in_row[W-2:0])
                 | (carry_q[W-2:0] & in_row[W-2:0]);

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_ACC);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum_o     = sum_q;
  assign carry_o   = carry_q;
`ifdef CSA_SEQ_CPA_EN
  assign result_o  = result_q;
`endif

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    row_cnt_d = row_cnt_q;
`ifdef CSA_SEQ_CPA_EN
    result_d  = result_q;
`endif

    if (clr) begin
      state_d   = S_IDLE;
      sum_d     = '0;
      carry_d   = '0;
      row_cnt_d = '0;
`ifdef CSA_SEQ_CPA_EN
      result_d  = '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            sum_d     = in_row;
            carry_d   = '0;
            row_cnt_d = CNT_W'(1);
            state_d   = (N_ROWS == 1) ? S_AFTER_LAST : S_ACC;
          end
        end
        S_ACC: begin
          if (accept) begin
            sum_d     = csa_sum;
            carry_d   = {csa_maj, 1'b0};
            row_cnt_d = row_cnt_q + CNT_W'(1);
            if (row_cnt_q == LAST_CNT) state_d = S_AFTER_LAST;
          end
        end
`ifdef CSA_SEQ_CPA_EN
        S_FINAL: begin
          result_d = sum_q + carry_q;
          state_d  = S_DONE;
        end
`endif
        S_DONE: begin
          // sum/carry stay visible after the handoff until the next first row.
          if (out_ready) begin
            state_d   = S_IDLE;
            row_cnt_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sum_q     <= '0;
      carry_q   <= '0;
      row_cnt_q <= '0;
`ifdef CSA_SEQ_CPA_EN
      result_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q   <= state_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      row_cnt_q <= row_cnt_d;
`ifdef CSA_SEQ_CPA_EN
      result_q  <= result_d;
`endif
    end
  end

endmodule

// File: tb/tb_csa_seq_accum.sv
// Randomized self-checking bench for csa_seq_accum (W=33, N_ROWS=3 plus an
// N_ROWS=1 instance); expected totals come from plain modular row sums.
module tb_csa_seq_accum;
  localparam int W = 33;
  localparam int N_ROWS = 3;
  typedef logic [W-1:0] word_t;
`ifdef CSA_SEQ_CPA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic  clk = 1'b0;
  logic  rst_n, clr, in_valid, out_ready;
  word_t in_row;
  logic  in_ready, out_valid, busy;
  word_t sum_o, carry_o;
  logic  b_in_valid, b_out_ready;
  word_t b_in_row;
  logic  b_in_ready, b_out_valid, b_busy;
  word_t b_sum, b_carry;
`ifdef CSA_SEQ_CPA_EN
  word_t result_o, b_result;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  csa_seq_accum #(.W(W), .N_ROWS(N_ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_o(sum_o), .carry_o(carry_o),
`ifdef CSA_SEQ_CPA_EN
    .result_o(result_o),
`endif
    .busy(busy)
  );

  csa_seq_accum #(.W(W), .N_ROWS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_row(b_in_row),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sum_o(b_sum), .carry_o(b_carry),
`ifdef CSA_SEQ_CPA_EN
    .result_o(b_result),
`endif
    .busy(b_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a row from a falling edge and returns at the falling edge after it is taken.
  task automatic push_row(input word_t row);
    int n = 0;
    in_valid = 1'b1;
    in_row   = row;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_for_row", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("out_valid", out_valid, 1);
  endtask

  task automatic check_total(input string tag, input word_t exp_total);
    word_t tot;
    tot = sum_o + carry_o;
    check(tag, tot, exp_total);
    check({tag, "_carry_lsb"}, carry_o[0], 0);
`ifdef CSA_SEQ_CPA_EN
    check({tag, "_result"}, result_o, exp_total);
`endif
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_handoff_busy", busy, 0);
    check("idle_after_handoff_valid", out_valid, 0);
  endtask

  initial begin
    word_t s0, c0, expected, row;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_row = '0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sum", sum_o, 0);
    check("rst_carry", carry_o, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef CSA_SEQ_CPA_EN
    check("rst_result", result_o, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Rows 5, 7, 9 back to back.
    push_row(33'd5);
    check("acc_busy", busy, 1);
    check("acc_in_ready", in_ready, 1);
    check("acc_out_valid", out_valid, 0);
    push_row(33'd7);
    push_row(33'd9);
    check("latency_valid", out_valid, (LAT == 1) ? 1 : 0);
    wait_out();
    check("579_sum", sum_o, 33'd1);
    check("579_carry", carry_o, 33'd20);
    check_total("579_total", 33'd21);
    release_out();

    // All-ones rows: the MSB carry must drop off.
    repeat (3) push_row(33'h1_FFFF_FFFF);
    wait_out();
    check_total("ones_total", 33'h1_FFFF_FFFD);

    // Stall in DONE with a row offered: nothing consumed, outputs frozen.
    s0 = sum_o;
    c0 = carry_o;
    in_valid = 1'b1;
    in_row   = 33'h0_0BAD_F00D;
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
      check("stall_sum", sum_o, s0);
      check("stall_carry", carry_o, c0);
    end
    in_valid = 1'b0;
    release_out();
    check("held_sum", sum_o, s0);
    check("held_carry", carry_o, c0);
    check("idle_in_ready", in_ready, 1);

    // Asynchronous reset mid-operation.
    push_row(33'd11);
    push_row(33'd13);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sum", sum_o, 0);
    check("midrst_carry", carry_o, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_row(33'd1);
    push_row(33'd2);
    push_row(33'd3);
    wait_out();
    check_total("after_rst_total", 33'd6);
    release_out();

    // clr beats a simultaneous row.
    push_row(33'd1);
    clr = 1'b1; in_valid = 1'b1; in_row = 33'd99;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_sum", sum_o, 0);
    check("clr_carry", carry_o, 0);
    check("clr_in_ready", in_ready, 1);
    repeat (3) push_row(33'd4);
    wait_out();
    check_total("after_clr_total", 33'd12);
    release_out();

    // Random operations with gaps and downstream back-pressure.
    for (int op = 0; op < 25; op++) begin
      expected = '0;
      for (int r = 0; r < N_ROWS; r++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        row = {1'($urandom_range(0, 1)), 32'($urandom)};
        expected = expected + row;
        push_row(row);
      end
      wait_out();
      check_total("rand_total", expected);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_out();
    end

    // N_ROWS=1 instance.
    b_in_valid = 1'b1;
    b_in_row   = 33'h1234;
    @(negedge clk);
    b_in_valid = 1'b0;
    if (LAT == 2) @(negedge clk);
    check("n1_valid", b_out_valid, 1);
    check("n1_sum", b_sum, 33'h1234);
    check("n1_carry", b_carry, 0);
`ifdef CSA_SEQ_CPA_EN
    check("n1_result", b_result, 33'h1234);
`endif
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    check("n1_idle_busy", b_busy, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
